// File: rtl/sm_hex_scan_ctrl_if.sv
// Value handshake between the register-read path and the scan controller.
// The source side (master) offers a packed hex value and watches ready.
// The display side (slave) accepts a value whenever its pending buffer is empty.
interface sm_hex_scan_ctrl_if #(
  parameter int DIGITS = 3
);
  logic [4*DIGITS-1:0] value;
  logic                valid;
  logic                ready;

  modport master (output value, output valid, input ready);
  modport slave  (input value, input valid, output ready);
endinterface

// File: rtl/sm_hex_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller.
// Each digit gets a slot of PERIOD cycles. The first BLANK cycles of a slot are
// dark, which stops ghosting while the digit enables change over.
// A value that is accepted is parked in a pending buffer. It is copied to the
// displayed (shadow) value only at the frame end, so a frame never mixes old
// and new digits.
// All pins are registered, so they lag the slot/digit counters by one cycle.
module sm_hex_scan_ctrl #(
  parameter int DIGITS = 3,
  parameter int PERIOD = 256,
  parameter int BLANK  = 16
) (
  input  logic                 clkIn,
  input  logic                 rst,
  sm_hex_scan_ctrl_if.slave    bus,
  input  logic                 lzb_en,
  input  logic [DIGITS-1:0]    dp_mask,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [DIGITS-1:0]    digit_sel,
  output logic                 frame_done
);

  localparam int SLOT_W = $clog2(PERIOD);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VAL_W  = 4 * DIGITS;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(PERIOD - 1);
  localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);

  // Segment pattern {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [VAL_W-1:0]  shadow_q, shadow_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              frame_done_q, frame_done_d;

  logic              frame_end;
  logic              take;
  logic [3:0]        nib;
  logic              dp_bit;
  logic              lead_blank;

  assign bus.ready = ~pend_full_q;
  assign take      = bus.valid && ~pend_full_q;
  assign frame_end = (idx_q == IDX_LAST) && (slot_q == SLOT_LAST);

  // Slot counter wraps every PERIOD cycles; the digit index steps on each wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    slot_d = slot_q + SLOT_W'(1);
    idx_d  = idx_q;
    if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Accept into pending; at frame end move pending, or a same-cycle offer, to shadow.
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    shadow_d    = shadow_q;
    if (frame_end) begin
      if (pend_full_q) begin
        shadow_d    = pend_q;
        pend_full_d = 1'b0;
      end else if (take) begin
        shadow_d = bus.value;
      end
    end else if (take) begin
      pend_d      = bus.value;
      pend_full_d = 1'b1;
    end
  end

  // Select the current digit's nibble and dp bit, and check whether it is a leading zero.
  always_comb begin
    nib        = 4'h0;
    dp_bit     = 1'b0;
    lead_blank = lzb_en && (idx_q != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib    = shadow_q[4*i +: 4];
        dp_bit = dp_mask[i];
      end
      if ((IDX_W'(i) >= idx_q) && (shadow_q[4*i +: 4] != 4'h0)) begin
        lead_blank = 1'b0;
      end
    end
  end

  // Pin values for the next cycle: dark during blanking or leading-zero suppression.
  always_comb begin
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    sel_d        = '1;
    frame_done_d = frame_end;
    if ((slot_q >= SLOT_BLANK) && !lead_blank) begin
      seg_d = hex_to_seg(nib);
      dp_d  = ~dp_bit;
      for (int i = 0; i < DIGITS; i++) begin
        sel_d[i] = (idx_q != IDX_W'(i));
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      slot_q       <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      shadow_q     <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      sel_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge values regardless of statement order.
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      shadow_q     <= shadow_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_sel  = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sm_hex_scan_ctrl.sv
// Directed bench for sm_hex_scan_ctrl with DIGITS=3, PERIOD=8, BLANK=2.
// k counts rising edges since reset release. After k edges the pins show the
// counter state k-1. In that state, slot = (k-1)%8 and digit = ((k-1)/8)%3.
// A frame end falls at state 23 mod 24, so frame_done is seen when k%24 == 0.
// Inputs are changed 1 time unit after an edge and take effect at the next edge.
module tb_sm_hex_scan_ctrl;
  localparam int DIGITS = 3;
  localparam int PERIOD = 8;
  localparam int BLANK  = 2;

  logic              clkIn = 1'b0;
  logic              rst;
  logic              lzb_en;
  logic [DIGITS-1:0] dp_mask;
  logic [6:0]        seg;
  logic              dp;
  logic [DIGITS-1:0] digit_sel;
  logic              frame_done;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int pulses;

  sm_hex_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  sm_hex_scan_ctrl #(.DIGITS(DIGITS), .PERIOD(PERIOD), .BLANK(BLANK)) dut (
    .clkIn      (clkIn),
    .rst        (rst),
    .bus        (bus),
    .lzb_en     (lzb_en),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clkIn = ~clkIn;

  task automatic tick();
    @(posedge clkIn);
    k++;
    #1;
  endtask

  task automatic run_until(input int n);
    while (k < n) tick();
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [2:0] sel_e, input logic [6:0] seg_e);
    check({tag, ".sel"}, {9'd0, digit_sel}, {9'd0, sel_e});
    check({tag, ".seg"}, {5'd0, seg}, {5'd0, seg_e});
  endtask

  task automatic check_reset_pins(input string tag);
    check_disp(tag, 3'b111, 7'h7F);
    check({tag, ".dp"}, {11'd0, dp}, 12'd1);
    check({tag, ".fd"}, {11'd0, frame_done}, 12'd0);
    check({tag, ".rdy"}, {11'd0, bus.ready}, 12'd1);
  endtask

  initial begin
    rst       = 1'b1;
    lzb_en    = 1'b0;
    dp_mask   = 3'b000;
    bus.value = 12'h000;
    bus.valid = 1'b0;
    #12;
    check_reset_pins("rst0");
    rst = 1'b0;

    // 1: blank, digit 0, blank, digit 1 with shadow 0; then async reset mid-frame
    tick();
    check_disp("lat1", 3'b111, 7'h7F);
    check("lat1.fd", {11'd0, frame_done}, 12'd0);
    tick();
    check_disp("blk2", 3'b111, 7'h7F);
    tick();
    check_disp("d0a", 3'b110, 7'h40);
    run_until(8);
    check_disp("d0b", 3'b110, 7'h40);
    tick();
    check_disp("blk9", 3'b111, 7'h7F);
    run_until(11);
    check_disp("d1a", 3'b101, 7'h40);
    run_until(13);
    check_disp("d1b", 3'b101, 7'h40);
    #1 rst = 1'b1;
    #1 check_reset_pins("rst_mid");
    #1 rst = 1'b0;
    k = 0;

    // 2: offer 123 with pending empty, held until frame end
    run_until(3);
    check_disp("r_d0", 3'b110, 7'h40);
    bus.value = 12'h123;
    bus.valid = 1'b1;
    tick();
    check("acc123.rdy", {11'd0, bus.ready}, 12'd0);
    bus.valid = 1'b0;
    run_until(12);
    check_disp("old_shadow", 3'b101, 7'h40);
    run_until(23);
    check("pend23.rdy", {11'd0, bus.ready}, 12'd0);
    check("pend23.fd", {11'd0, frame_done}, 12'd0);
    tick();
    check("commit24.rdy", {11'd0, bus.ready}, 12'd1);
    check("commit24.fd", {11'd0, frame_done}, 12'd1);
    tick();
    check("fd25", {11'd0, frame_done}, 12'd0);
    run_until(27);
    check_disp("v123.d0", 3'b110, 7'h30);
    run_until(35);
    check_disp("v123.d1", 3'b101, 7'h24);
    run_until(43);
    check_disp("v123.d2", 3'b011, 7'h79);

    // 3: ABC accepted, then 456 held while ready is low
    run_until(50);
    bus.value = 12'hABC;
    bus.valid = 1'b1;
    tick();
    check("accABC.rdy", {11'd0, bus.ready}, 12'd0);
    bus.value = 12'h456;
    run_until(71);
    check("hold71.rdy", {11'd0, bus.ready}, 12'd0);
    tick();
    check("free72.rdy", {11'd0, bus.ready}, 12'd1);
    tick();
    check("acc456.rdy", {11'd0, bus.ready}, 12'd0);
    bus.valid = 1'b0;
    run_until(75);
    check_disp("vABC.d0", 3'b110, 7'h46);
    run_until(83);
    check_disp("vABC.d1", 3'b101, 7'h03);
    run_until(91);
    check_disp("vABC.d2", 3'b011, 7'h08);
    run_until(96);
    check("commit96.rdy", {11'd0, bus.ready}, 12'd1);
    run_until(99);
    check_disp("v456.d0", 3'b110, 7'h02);
    run_until(107);
    check_disp("v456.d1", 3'b101, 7'h12);
    run_until(115);
    check_disp("v456.d2", 3'b011, 7'h19);

    // 4: leading-zero blanking
    run_until(100);
    lzb_en    = 1'b1;
    bus.value = 12'h005;
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    run_until(123);
    check_disp("lz005.d0", 3'b110, 7'h12);
    run_until(131);
    check_disp("lz005.d1", 3'b111, 7'h7F);
    check("lz005.d1.dp", {11'd0, dp}, 12'd1);
    run_until(139);
    check_disp("lz005.d2", 3'b111, 7'h7F);

    bus.value = 12'h000;
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    run_until(147);
    check_disp("lz000.d0", 3'b110, 7'h40);
    run_until(155);
    check_disp("lz000.d1", 3'b111, 7'h7F);

    bus.value = 12'h102;
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    run_until(171);
    check_disp("lz102.d0", 3'b110, 7'h24);
    run_until(179);
    check_disp("lz102.d1", 3'b101, 7'h40);
    run_until(187);
    check_disp("lz102.d2", 3'b011, 7'h79);

    // 5: offer exactly on the frame-end cycle with pending empty
    run_until(191);
    lzb_en = 1'b0;
    check("fe191.rdy", {11'd0, bus.ready}, 12'd1);
    bus.value = 12'h9E8;
    bus.valid = 1'b1;
    tick();
    check("direct192.rdy", {11'd0, bus.ready}, 12'd1);
    bus.valid = 1'b0;
    run_until(195);
    check("direct195.rdy", {11'd0, bus.ready}, 12'd1);
    check_disp("v9E8.d0", 3'b110, 7'h00);
    run_until(203);
    check_disp("v9E8.d1", 3'b101, 7'h06);
    run_until(211);
    check_disp("v9E8.d2", 3'b011, 7'h18);

    // 6: free-run 5 frames, dp on digit 1 only, frame_done every 24 cycles
    dp_mask = 3'b010;
    run_until(216);
    pulses = 0;
    for (int n = 0; n < 5 * DIGITS * PERIOD; n++) begin
      tick();
      check("run.fd", {11'd0, frame_done}, {11'd0, (k % 24) == 0});
      check("run.dp", {11'd0, dp},
            {11'd0, !(((k - 1) % 24) >= 10 && ((k - 1) % 24) <= 15)});
      if (frame_done) pulses++;
    end
    check("run.pulses", 12'(pulses), 12'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sm_hex_scan_ctrl.md
Name: sm_hex_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-segment 7-segment display with DIGITS digits. It accepts a packed hex value over a valid/ready handshake and holds it in a pending buffer. The value is committed to the display only at a frame boundary, so no frame ever shows mixed old and new digits. It drives one digit at a time with a blanking gap between digits to prevent ghosting, and optionally suppresses leading zeros. It sits between the core's register-read path and the board display pins.

Parameters:
DIGITS, 3, number of digits scanned (1..8)
PERIOD, 256, clkIn cycles per digit slot (PERIOD > BLANK)
BLANK, 16, cycles at the start of each slot with all outputs off (>= 1)

Ports:
clkIn  in  1  system clock
rst  in  1  asynchronous reset, active-high
value  in  4*DIGITS  hex value; nibble i drives digit i; digit 0 = value[3:0] = least significant
valid  in  1  value offered
ready  out  1  pending buffer empty; transfer occurs when valid && ready
lzb_en  in  1  leading-zero blanking enable (sampled live)
dp_mask  in  DIGITS  decimal point on for digit i when bit i = 1 (sampled live)
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
digit_sel  out  DIGITS  one-hot digit enable, active-low
frame_done  out  1  one-cycle pulse at end of each full scan frame

Behaviour:
- Reset (async, any time, including mid-frame):
  - seg = 7'h7F, dp = 1, digit_sel = all ones, frame_done = 0, ready = 1.
  - Pending buffer is empty; shadow (displayed) value = 0.
  - slot counter = 0, digit index = 0.
- Counters:
  - The slot counter counts 0..PERIOD-1 and then wraps.
  - On wrap, the digit index increments 0..DIGITS-1 and then wraps to 0.
  - A frame is DIGITS*PERIOD cycles.
- Frame end: the cycle where index = DIGITS-1 and slot = PERIOD-1.
- Handshake:
  - valid && ready loads value into pending; ready drops on the next cycle.
  - When ready = 0, value and valid are ignored. No data is lost; the source must hold valid until it sees ready.
- Commit at frame end:
  - If pending is full, shadow <= pending, pending is cleared, and ready = 1 on the next cycle.
  - If pending is empty and valid && ready in the same cycle, shadow <= value directly and pending stays empty.
  - The new shadow is first visible in the frame starting on the next cycle.
- Outputs are registered and reflect the counter state of the previous cycle (1-cycle latency).
- Blank phase (slot < BLANK): seg = 7'h7F, dp = 1, digit_sel = all ones.
- Active phase (slot >= BLANK):
  - digit_sel[index] = 0, all other bits 1.
  - seg = hex decode of shadow nibble[index], using the standard active-low table:
    0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0011000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
  - dp = ~dp_mask[index].
- Leading-zero blanking: with lzb_en = 1, digit i (i >= 1) is blanked when nibbles i..DIGITS-1 of shadow are all zero.
  - A blanked digit keeps digit_sel all ones, seg = 7'h7F and dp = 1 for its whole slot; its slot time is still consumed.
  - Digit 0 is never blanked.
- frame_done: registered 1-cycle pulse, high the cycle after frame end (aligned with outputs).

Test Plan:
(Use DIGITS=3, PERIOD=8, BLANK=2.)
1. Reset then release -> outputs off for 1 latency cycle plus 2 blank cycles. Then digit_sel = 3'b110 with seg = 1000000 for 6 cycles, then 2 blank cycles, then digit_sel = 3'b101. Repeat the sequence with rst asserted at cycle 13 -> outputs return to reset values asynchronously.
2. Offer value = 12'h123 at cycle 3 -> ready = 0 from cycle 4 until frame end (cycle 23), ready = 1 at cycle 24. From the next frame, digit 0/1/2 show 0110000/0100100/1111001.
3. Offer 12'hABC and hold valid while ready = 0, then change value to 12'h456 -> only 12'hABC is accepted; 12'h456 transfers after ready returns and displays one frame later.
4. lzb_en = 1:
   - value 12'h005 -> digits 1 and 2 keep digit_sel all ones; digit 0 shows 0010010.
   - value 12'h000 -> digit 0 shows 1000000.
   - value 12'h102 -> digit 1 shows 1000000 (not blanked).
5. valid pulsed on frame end cycle with pending empty -> new value is visible in the very next frame and ready never drops.
6. Free-run 5 frames with dp_mask = 3'b010 -> frame_done pulses exactly every 24 cycles; dp = 0 only during digit 1 active cycles.
